div_ctrl: RTL



---
 rtl/div_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/div_ctrl.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer using a restoring shift-subtract loop.
// Optional macro DIV_EARLY_OUT_EN: finish zero-divisor and |dividend| < |divisor| cases at once.
module div_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            hold_req_o,
    output logic            ready_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic               rem_sel;
    logic               neg_q;
    logic               neg_r;
    logic               ready_q;
    logic [XLEN-1:0]    dvd;
    logic [XLEN-1:0]    dsr;
    logic [XLEN-1:0]    rem;
    logic [CNT_W-1:0]   cnt;

    logic               signed_op;
    logic               div_zero;
    logic               accept;
    logic [XLEN-1:0]    a_abs;
    logic [XLEN-1:0]    b_abs;
    logic [XLEN:0]      rem_ext;
    logic               ge;
    logic [XLEN-1:0]    rem_nx;
    logic [XLEN-1:0]    dvd_nx;
    logic [XLEN-1:0]    q_fix;
    logic [XLEN-1:0]    r_fix;
    logic [XLEN-1:0]    fin;

    assign signed_op = ~op_i[0];
    assign div_zero  = (divisor_i == '0);
    assign accept    = (state == IDLE) && start_i && !flush_i;
    assign a_abs     = (signed_op && dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
    assign b_abs     = (signed_op && divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;

    // The partial remainder is kept one bit wider during the compare so divisors
    // above 2^31 cannot lose the carried-out top bit.
    assign rem_ext = {rem, dvd[XLEN-1]};
    assign ge      = (rem_ext >= {1'b0, dsr});
    assign rem_nx  = ge ? (rem_ext[XLEN-1:0] - dsr) : rem_ext[XLEN-1:0];
    assign dvd_nx  = {dvd[XLEN-2:0], ge};
    assign q_fix   = neg_q ? -dvd_nx : dvd_nx;
    assign r_fix   = neg_r ? -rem_nx : rem_nx;
    assign fin     = rem_sel ? r_fix : q_fix;

`ifdef DIV_EARLY_OUT_EN
    logic            early;
    logic [XLEN-1:0] early_res;
    assign early     = div_zero || (a_abs < b_abs);
    assign early_res = op_i[1] ? dividend_i : (div_zero ? '1 : '0);
`endif

    assign busy_o     = (state != IDLE);
    assign hold_req_o = accept || (state == CALC);
    assign ready_o    = ready_q && !flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rem_sel   <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            ready_q   <= 1'b0;
            dvd       <= '0;
            dsr       <= '0;
            rem       <= '0;
            cnt       <= '0;
            result_o  <= '0;
            rd_addr_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (accept) begin
                        rem_sel   <= op_i[1];
                        rd_addr_o <= rd_addr_i;
                        // Divide by zero skips fix-up and shifts the raw dividend
                        // through, leaving it intact as the remainder.
                        neg_q     <= signed_op && !div_zero && (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
                        neg_r     <= signed_op && !div_zero && dividend_i[XLEN-1];
                        dvd       <= div_zero ? dividend_i : a_abs;
                        dsr       <= b_abs;
                        rem       <= '0;
                        cnt       <= '0;
`ifdef DIV_EARLY_OUT_EN
                        if (early) begin
                            result_o <= early_res;
                            ready_q  <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state    <= CALC;
                        end
`else
                        state     <= CALC;
`endif
                    end
                end
                CALC: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        rem <= rem_nx;
                        dvd <= dvd_nx;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(XLEN - 1)) begin
                            result_o <= fin;
                            ready_q  <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    ready_q <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
